vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLKS_PER_PIXEL, default 4, clk cycles per pixel.
REQ-002 Parameter H_VISIBLE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, horizontal pixel counts.
REQ-003 Parameter V_VISIBLE/V_FP/V_SYNC/V_BP, defaults 480/10/2/29, vertical line counts.
REQ-004 clk  input  1  system clock (100 MHz nominal).
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  count enable; low freezes all counters and outputs.
REQ-007 H_counter  output  12  clk-cycle index within line, 0..CLKS_PER_PIXEL*H_total-1 (0..3199 at defaults).
REQ-008 V_counter  output  10  line index within frame, 0..V_total-1 (0..520).
REQ-009 hsync, vsync  output  1 each  sync pulses, active-low.
REQ-010 display_en  output  1  high inside visible region.
REQ-011 pixel_x  output  10, pixel_y  output  9  visible pixel coordinates; 0 when display_en low.
REQ-012 pixel_tick  output  1  one-cycle pulse on last clk of each pixel.
REQ-013 frame_end  output  1  one-cycle pulse when V_counter==V_total-1 and H_counter==H_max.
REQ-014 rgb  output  12  4:4:4 colour (see Configuration).

Function
REQ-015 H_counter SHALL increment by 1 per clk with en high; wrap H_max->0.
REQ-016 V_counter SHALL increment exactly on H wrap; wrap V_total-1->0 on the same cycle H wraps.
REQ-017 Each axis SHALL run FSM ACTIVE->FRONT->SYNC->BACK->ACTIVE, transitioning at region boundaries (defaults H in clk: 0/2560/2624/3008; V in lines: 0/480/490/492).
REQ-018 Horizontal FSM advances on clk; vertical FSM advances only on H wrap.
REQ-019 All outputs SHALL be registered and cycle-aligned with H_counter/V_counter: hsync==0 exactly while H_counter in [2624,3007]; vsync==0 exactly while V_counter in [490,491].
REQ-020 display_en = (H state ACTIVE) AND (V state ACTIVE), same cycle as counters.
REQ-021 pixel_x = H_counter / CLKS_PER_PIXEL, pixel_y = V_counter, while display_en; no divider (sub-pixel counter).
REQ-022 pixel_tick high when sub-pixel count == CLKS_PER_PIXEL-1, independent of display_en.
REQ-023 en low: counters, FSM states, sync levels held; pixel_tick and frame_end forced 0.
REQ-024 Timing parameters SHALL be checked at elaboration: totals fit output widths, every region >=1.

Reset
REQ-025 reset SHALL dominate en and clk.
REQ-026 Reset values: H_counter=0, V_counter=0, both FSMs ACTIVE, hsync=1, vsync=1, display_en=1, pixel_x=0, pixel_y=0, pixel_tick=0, frame_end=0, rgb=0.
REQ-027 First clk after reset release with en high SHALL produce H_counter=1; reset mid-frame restarts at frame origin with no partial sync pulse.

Configuration
REQ-028 Macro VGA_TIMING_TEST_PATTERN_EN defined: rgb drives 8 vertical colour bars, each H_VISIBLE/8 pixels wide, order black, blue, green, cyan, red, magenta, yellow, white (each channel 4'hF or 4'h0); rgb=0 when display_en low.
REQ-029 Macro undefined: rgb tied 12'h000, no pattern logic synthesised; all other behaviour identical.

Structure
REQ-030 Package vga_timing_pkg SHALL hold axis state enum (ACTIVE, FRONT, SYNC, BACK), default timing constants, colour-bar table.
REQ-031 Sub-module vga_axis_fsm (region FSM + boundary compare, instantiated once per axis) SHALL be used.

Verification
REQ-032 Reset then 3200 clks en=1 -> H_counter 3199->0 on wrap cycle, V_counter 0->1 same cycle.
REQ-033 Run one line -> hsync low exactly 384 consecutive clks starting at H_counter=2624; display_en high 2560 clks from H=0.
REQ-034 Run full frame -> vsync low for lines 490-491 only (6400 clks); frame_end pulses once every 1,667,200 clks, at V=520,H=3199.
REQ-035 Drop en for 50 clks at H=1000 -> all outputs frozen, no pixel_tick; resumes at H=1001.
REQ-036 Assert reset at V=300,H=1500 -> all outputs at reset values next cycle, asynchronously.
REQ-037 With VGA_TIMING_TEST_PATTERN_EN: pixel_x=80,y=0 -> rgb=12'h00F; pixel_x=639 -> 12'hFFF; blanking -> 12'h000.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared types and constants for the VGA timing generator.
//   - axis_state_e : region state of one timing axis (ACTIVE, FRONT, SYNC, BACK)
//   - DEF_*        : default 640x480 timing (horizontal in pixels, vertical in lines)
//   - *_W          : fixed output widths of vga_timing_gen
//   - BAR_RGB      : 4:4:4 colour-bar table, index 0 is the leftmost bar
//   - axis_total() : sum of the four region lengths of one axis
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } axis_state_e;

  localparam int unsigned DEF_CLKS_PER_PIXEL = 4;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;

  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 29;

  localparam int unsigned HCNT_W   = 12;
  localparam int unsigned VCNT_W   = 10;
  localparam int unsigned PIXX_W   = 10;
  localparam int unsigned PIXY_W   = 9;
  localparam int unsigned RGB_W    = 12;
  localparam int unsigned NUM_BARS = 8;

  // black, blue, green, cyan, red, magenta, yellow, white (left to right)
  localparam logic [NUM_BARS-1:0][RGB_W-1:0] BAR_RGB = {
    12'hFFF, 12'hFF0, 12'hF0F, 12'hF00,
    12'h0FF, 12'h0F0, 12'h00F, 12'h000
  };

  function automatic int unsigned axis_total(input int unsigned visible,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return visible + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// vga_axis_fsm: position counter and region FSM for one timing axis.
// Region lengths are given in counter units (clks for horizontal, lines for
// vertical). The counter advances by one on each step_i and wraps after the
// back porch; the FSM moves ACTIVE->FRONT->SYNC->BACK->ACTIVE on the step that
// leaves each region's last count.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   step_i        : advance the axis by one position this cycle
//   cnt_o         : registered position within the axis period
//   cnt_nxt_c     : position the counter takes at the next edge
//   state_nxt_c   : region the FSM takes at the next edge
//   last_nxt_c    : next position is the final one of the period
module vga_axis_fsm
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned LEN_ACTIVE = 2560,
  parameter int unsigned LEN_FRONT  = 64,
  parameter int unsigned LEN_SYNC   = 384,
  parameter int unsigned LEN_BACK   = 192
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_nxt_c,
  output axis_state_e      state_nxt_c,
  output logic             last_nxt_c
);

  localparam int unsigned END_ACTIVE = LEN_ACTIVE;
  localparam int unsigned END_FRONT  = END_ACTIVE + LEN_FRONT;
  localparam int unsigned END_SYNC   = END_FRONT + LEN_SYNC;
  localparam int unsigned END_TOTAL  = END_SYNC + LEN_BACK;

  localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(END_ACTIVE - 1);
  localparam logic [CNT_W-1:0] LAST_FRONT  = CNT_W'(END_FRONT - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(END_SYNC - 1);
  localparam logic [CNT_W-1:0] LAST_TOTAL  = CNT_W'(END_TOTAL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  axis_state_e      state_q;
  axis_state_e      state_d;

  // State and position registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= ACTIVE;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Next position and region; each region ends on its last count
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (step_i) begin
      if (cnt_q == LAST_TOTAL) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      case (state_q)
        ACTIVE:  if (cnt_q == LAST_ACTIVE) state_d = FRONT;
        FRONT:   if (cnt_q == LAST_FRONT)  state_d = SYNC;
        SYNC:    if (cnt_q == LAST_SYNC)   state_d = BACK;
        BACK:    if (cnt_q == LAST_TOTAL)  state_d = ACTIVE;
        default: state_d = ACTIVE;
      endcase
    end
  end

  assign cnt_o       = cnt_q;
  assign cnt_nxt_c   = cnt_d;
  assign state_nxt_c = state_d;
  assign last_nxt_c  = (cnt_d == LAST_TOTAL);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/timing generator with pixel coordinates.
// All outputs are registered from next-state values so every output is
// cycle-aligned with H_counter/V_counter.
// Optional feature: define VGA_TIMING_TEST_PATTERN_EN to drive 8 vertical
// colour bars on rgb; otherwise rgb is tied to zero.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   en          : count enable; low freezes counters, states and sync levels
//   H_counter   : clk index within the line
//   V_counter   : line index within the frame
//   hsync/vsync : active-low sync pulses
//   display_en  : high inside the visible region
//   pixel_x/y   : visible pixel coordinates, 0 outside the visible region
//   pixel_tick  : pulse on the last clk of each pixel
//   frame_end   : pulse on the last clk of the frame
//   rgb         : 4:4:4 colour
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLKS_PER_PIXEL = DEF_CLKS_PER_PIXEL,
  parameter int unsigned H_VISIBLE      = DEF_H_VISIBLE,
  parameter int unsigned H_FP           = DEF_H_FP,
  parameter int unsigned H_SYNC         = DEF_H_SYNC,
  parameter int unsigned H_BP           = DEF_H_BP,
  parameter int unsigned V_VISIBLE      = DEF_V_VISIBLE,
  parameter int unsigned V_FP           = DEF_V_FP,
  parameter int unsigned V_SYNC         = DEF_V_SYNC,
  parameter int unsigned V_BP           = DEF_V_BP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [HCNT_W-1:0] H_counter,
  output logic [VCNT_W-1:0] V_counter,
  output logic              hsync,
  output logic              vsync,
  output logic              display_en,
  output logic [PIXX_W-1:0] pixel_x,
  output logic [PIXY_W-1:0] pixel_y,
  output logic              pixel_tick,
  output logic              frame_end,
  output logic [RGB_W-1:0]  rgb
);

  localparam int unsigned H_TOTAL_PIX = axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int unsigned H_TOTAL_CLK = CLKS_PER_PIXEL * H_TOTAL_PIX;
  localparam int unsigned V_TOTAL     = axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
  localparam int unsigned SUB_W       = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CLKS_PER_PIXEL - 1);

  // Reject timings that do not fit the fixed output widths
  if (CLKS_PER_PIXEL < 1 || H_VISIBLE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_VISIBLE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_region
    $error("vga_timing_gen: every timing region must be at least 1");
  end
  if (H_TOTAL_CLK > (2 ** HCNT_W)) begin : g_chk_h_total
    $error("vga_timing_gen: CLKS_PER_PIXEL*H_total does not fit H_counter");
  end
  if (V_TOTAL > (2 ** VCNT_W)) begin : g_chk_v_total
    $error("vga_timing_gen: V_total does not fit V_counter");
  end
  if (H_VISIBLE > (2 ** PIXX_W) || V_VISIBLE > (2 ** PIXY_W)) begin : g_chk_visible
    $error("vga_timing_gen: visible area does not fit pixel_x/pixel_y");
  end

  logic [HCNT_W-1:0] h_cnt_q;
  logic [HCNT_W-1:0] h_cnt_d;
  axis_state_e       h_state_d;
  logic              h_last_d;
  logic [VCNT_W-1:0] v_cnt_q;
  logic [VCNT_W-1:0] v_cnt_d;
  axis_state_e       v_state_d;
  logic              v_last_d;
  logic              v_step;

  logic              h_last_q;
  logic [SUB_W-1:0]  sub_q;
  logic [SUB_W-1:0]  sub_d;
  logic [HCNT_W-1:0] px_q;
  logic [HCNT_W-1:0] px_d;

  logic              hsync_q;
  logic              hsync_d;
  logic              vsync_q;
  logic              vsync_d;
  logic              de_q;
  logic              de_d;
  logic [PIXX_W-1:0] pixel_x_q;
  logic [PIXX_W-1:0] pixel_x_d;
  logic [PIXY_W-1:0] pixel_y_q;
  logic [PIXY_W-1:0] pixel_y_d;
  logic              tick_q;
  logic              tick_d;
  logic              fend_q;
  logic              fend_d;

  // Horizontal axis runs in clk units
  vga_axis_fsm #(
    .CNT_W      (HCNT_W),
    .LEN_ACTIVE (CLKS_PER_PIXEL * H_VISIBLE),
    .LEN_FRONT  (CLKS_PER_PIXEL * H_FP),
    .LEN_SYNC   (CLKS_PER_PIXEL * H_SYNC),
    .LEN_BACK   (CLKS_PER_PIXEL * H_BP)
  ) u_h_axis (
    .clk         (clk),
    .reset       (reset),
    .step_i      (en),
    .cnt_o       (h_cnt_q),
    .cnt_nxt_c   (h_cnt_d),
    .state_nxt_c (h_state_d),
    .last_nxt_c  (h_last_d)
  );

  // Vertical axis steps on the horizontal wrap
  assign v_step = en & h_last_q;

  vga_axis_fsm #(
    .CNT_W      (VCNT_W),
    .LEN_ACTIVE (V_VISIBLE),
    .LEN_FRONT  (V_FP),
    .LEN_SYNC   (V_SYNC),
    .LEN_BACK   (V_BP)
  ) u_v_axis (
    .clk         (clk),
    .reset       (reset),
    .step_i      (v_step),
    .cnt_o       (v_cnt_q),
    .cnt_nxt_c   (v_cnt_d),
    .state_nxt_c (v_state_d),
    .last_nxt_c  (v_last_d)
  );

  // Sub-pixel and pixel counters replace a divide of H_counter
  always_comb begin
    sub_d = sub_q;
    px_d  = px_q;
    if (en) begin
      if (sub_q == SUB_LAST) begin
        sub_d = '0;
        px_d  = h_last_q ? '0 : px_q + HCNT_W'(1);
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  // Output next-state, derived from the counters' next values
  always_comb begin
    hsync_d   = (h_state_d != SYNC);
    vsync_d   = (v_state_d != SYNC);
    de_d      = (h_state_d == ACTIVE) && (v_state_d == ACTIVE);
    pixel_x_d = '0;
    pixel_y_d = '0;
    if (de_d) begin
      pixel_x_d = PIXX_W'(px_d);
      pixel_y_d = PIXY_W'(v_cnt_d);
    end
    tick_d = en & (sub_d == SUB_LAST);
    fend_d = en & h_last_d & v_last_d;
  end

  // Output and helper registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_last_q  <= 1'b0;
      sub_q     <= '0;
      px_q      <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      de_q      <= 1'b1;
      pixel_x_q <= '0;
      pixel_y_q <= '0;
      tick_q    <= 1'b0;
      fend_q    <= 1'b0;
    end else begin
      h_last_q  <= h_last_d;
      sub_q     <= sub_d;
      px_q      <= px_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      pixel_x_q <= pixel_x_d;
      pixel_y_q <= pixel_y_d;
      tick_q    <= tick_d;
      fend_q    <= fend_d;
    end
  end

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_VISIBLE / NUM_BARS;

  logic [2:0]       bar_idx;
  logic [RGB_W-1:0] rgb_q;
  logic [RGB_W-1:0] rgb_d;

  // Bar index by constant boundary compares; trailing remainder pixels join the last bar
  always_comb begin
    bar_idx = '0;
    for (int unsigned b = 1; b < NUM_BARS; b++) begin
      if (px_d >= HCNT_W'(b * BAR_W)) bar_idx = 3'(b);
    end
    rgb_d = de_d ? BAR_RGB[bar_idx] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb = rgb_q;
`else
  assign rgb = '0;
`endif

  assign H_counter  = h_cnt_q;
  assign V_counter  = v_cnt_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign display_en = de_q;
  assign pixel_x    = pixel_x_q;
  assign pixel_y    = pixel_y_q;
  assign pixel_tick = tick_q;
  assign frame_end  = fend_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// dut_a uses the default 640x480 timing; dut_b uses a tiny timing so whole
// frames fit in a short run. Expected values come from a per-cycle reference
// of the counters and region boundaries.
module tb_vga_timing_gen;

  logic        clk;
  logic        reset;
  logic        en_a;
  logic        en_b;

  logic [11:0] h_a;
  logic [9:0]  v_a;
  logic        hs_a, vs_a, de_a, pt_a, fe_a;
  logic [9:0]  px_a;
  logic [8:0]  py_a;
  logic [11:0] rgb_a;

  logic [11:0] h_b;
  logic [9:0]  v_b;
  logic        hs_b, vs_b, de_b, pt_b, fe_b;
  logic [9:0]  px_b;
  logic [8:0]  py_b;
  logic [11:0] rgb_b;

  int n_checks = 0;
  int n_fail   = 0;

  int ha, va, hb, vb;

  vga_timing_gen dut_a (
    .clk        (clk),
    .reset      (reset),
    .en         (en_a),
    .H_counter  (h_a),
    .V_counter  (v_a),
    .hsync      (hs_a),
    .vsync      (vs_a),
    .display_en (de_a),
    .pixel_x    (px_a),
    .pixel_y    (py_a),
    .pixel_tick (pt_a),
    .frame_end  (fe_a),
    .rgb        (rgb_a)
  );

  // Tiny timing: 2 clk/pixel, H 8/2/3/2 pixels (30 clks), V 4/1/2/1 lines
  vga_timing_gen #(
    .CLKS_PER_PIXEL (2),
    .H_VISIBLE      (8),
    .H_FP           (2),
    .H_SYNC         (3),
    .H_BP           (2),
    .V_VISIBLE      (4),
    .V_FP           (1),
    .V_SYNC         (2),
    .V_BP           (1)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .en         (en_b),
    .H_counter  (h_b),
    .V_counter  (v_b),
    .hsync      (hs_b),
    .vsync      (vs_b),
    .display_en (de_b),
    .pixel_x    (px_b),
    .pixel_y    (py_b),
    .pixel_tick (pt_b),
    .frame_end  (fe_b),
    .rgb        (rgb_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input bit de, input int px, input int w);
    int b;
    logic [11:0] c;
    b = (w > 0) ? px / w : 7;
    if (b > 7) b = 7;
    case (b)
      0:       c = 12'h000;
      1:       c = 12'h00F;
      2:       c = 12'h0F0;
      3:       c = 12'h0FF;
      4:       c = 12'hF00;
      5:       c = 12'hF0F;
      6:       c = 12'hFF0;
      default: c = 12'hFFF;
    endcase
`ifndef VGA_TIMING_TEST_PATTERN_EN
    c = 12'h000;
`endif
    return de ? c : 12'h000;
  endfunction

  task automatic check_a();
    bit de;
    int px;
    de = (ha < 2560) && (va < 480);
    px = de ? ha / 4 : 0;
    chk("a_H_counter", h_a, ha);
    chk("a_V_counter", v_a, va);
    chk("a_hsync", hs_a, !(ha >= 2624 && ha < 3008));
    chk("a_vsync", vs_a, !(va >= 490 && va < 492));
    chk("a_display_en", de_a, de);
    chk("a_pixel_x", px_a, px);
    chk("a_pixel_y", py_a, de ? va : 0);
    chk("a_pixel_tick", pt_a, en_a && (ha % 4 == 3));
    chk("a_frame_end", fe_a, en_a && va == 520 && ha == 3199);
    chk("a_rgb", rgb_a, exp_rgb(de, px, 80));
  endtask

  task automatic check_b();
    bit de;
    int px;
    de = (hb < 16) && (vb < 4);
    px = de ? hb / 2 : 0;
    chk("b_H_counter", h_b, hb);
    chk("b_V_counter", v_b, vb);
    chk("b_hsync", hs_b, !(hb >= 20 && hb < 26));
    chk("b_vsync", vs_b, !(vb >= 5 && vb < 7));
    chk("b_display_en", de_b, de);
    chk("b_pixel_x", px_b, px);
    chk("b_pixel_y", py_b, de ? vb : 0);
    chk("b_pixel_tick", pt_b, en_b && (hb % 2 == 1));
    chk("b_frame_end", fe_b, en_b && vb == 7 && hb == 29);
    chk("b_rgb", rgb_b, exp_rgb(de, px, 1));
  endtask

  task automatic step_a();
    @(posedge clk);
    #1;
    if (en_a) begin
      ha++;
      if (ha == 3200) begin
        ha = 0;
        va++;
        if (va == 521) va = 0;
      end
    end
    check_a();
  endtask

  task automatic step_b();
    @(posedge clk);
    #1;
    if (en_b) begin
      hb++;
      if (hb == 30) begin
        hb = 0;
        vb++;
        if (vb == 8) vb = 0;
      end
    end
    check_b();
  endtask

  initial begin
    int hs_low;
    int de_high;
    int tick_seen;
    int fe_count;
    int fe_first;
    int vs_low;

    reset = 1'b1;
    en_a  = 1'b0;
    en_b  = 1'b0;
    ha = 0; va = 0; hb = 0; vb = 0;

    // Reset values on both instances
    repeat (3) @(posedge clk);
    #1;
    check_a();
    check_b();

    // First line of the default timing
    reset = 1'b0;
    en_a  = 1'b1;
    hs_low  = 0;
    de_high = 0;
    step_a();
    chk("first_clk_H", h_a, 1);
    if (!hs_a) hs_low++;
    if (de_a) de_high++;
    for (int k = 2; k <= 3200; k++) begin
      step_a();
      if (!hs_a) hs_low++;
      if (de_a) de_high++;
    end
    chk("line_wrap_H", h_a, 0);
    chk("line_wrap_V", v_a, 1);
    chk("hsync_low_clks", hs_low, 384);
    chk("display_en_high_clks", de_high, 2560);

    // Freeze with en low at H=1000
    repeat (1000) step_a();
    chk("freeze_start_H", h_a, 1000);
    en_a = 1'b0;
    tick_seen = 0;
    for (int k = 0; k < 50; k++) begin
      step_a();
      tick_seen = tick_seen | int'(pt_a);
    end
    chk("freeze_hold_H", h_a, 1000);
    chk("freeze_no_tick", tick_seen, 0);
    en_a = 1'b1;
    step_a();
    chk("resume_H", h_a, 1001);

    // Asynchronous reset in the middle of hsync
    repeat (1699) step_a();
    chk("pre_reset_H", h_a, 2700);
    chk("pre_reset_hsync", hs_a, 0);
    #2;
    reset = 1'b1;
    #1;
    ha = 0;
    va = 0;
    check_a();
    @(posedge clk);
    #1;
    check_a();
    reset = 1'b0;
    step_a();
    chk("restart_H", h_a, 1);
    chk("restart_V", v_a, 0);

    // Tiny timing: two full frames
    en_a = 1'b0;
    reset = 1'b1;
    #1;
    hb = 0;
    vb = 0;
    check_b();
    @(posedge clk);
    #1;
    reset = 1'b0;
    en_b = 1'b1;
    fe_count = 0;
    fe_first = -1;
    vs_low   = 0;
    for (int k = 1; k <= 480; k++) begin
      step_b();
      if (fe_b) begin
        fe_count++;
        if (fe_first < 0) fe_first = k;
      end
      if (!vs_b) vs_low++;
    end
    chk("b_frame_end_count", fe_count, 2);
    chk("b_frame_end_first_clk", fe_first, 239);
    chk("b_vsync_low_clks", vs_low, 120);
    chk("b_frame_wrap_H", h_b, 0);
    chk("b_frame_wrap_V", v_b, 0);

    // Asynchronous reset in the middle of vsync
    repeat (160) step_b();
    chk("b_pre_reset_V", v_b, 5);
    chk("b_pre_reset_vsync", vs_b, 0);
    #2;
    reset = 1'b1;
    #1;
    hb = 0;
    vb = 0;
    check_b();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step_b();
    chk("b_restart_H", h_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
